// File: rtl/moving_average_decimator.sv
// moving_average_decimator: integrate-and-dump decimator behind MovingAverage2.
// Averages blocks of 2^LOG2_DECIM signed 8-bit samples into one signed 8-bit
// result. Results wait in a FIFO_DEPTH-entry queue with a valid/ready output.
// A result that arrives when the queue is full is dropped and counted.
// Optional macro MAVG_DECIM_ROUND_EN: round half toward +inf instead of floor.
module moving_average_decimator #(
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic signed [7:0] avg_i,
  input  logic              avg_valid_i,
  output logic signed [7:0] dec_o,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [7:0]        drop_cnt_o
);

  localparam int L   = LOG2_DECIM;
  localparam int AW  = 8 + L;
  localparam int PHW = (L == 0) ? 1 : L;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'((1 << L) - 1);

  // ---------------- integrate-and-dump ----------------
  logic [PHW-1:0]        ph;
  logic signed [AW-1:0]  acc;
  logic signed [AW:0]    sum, sum_adj;
  logic signed [7:0]     res_d, res_q;
  logic                  push_q;
  logic                  last;

  assign last = (ph == PH_LAST);

  // Block sum including the current sample; one guard bit keeps the rounding add exact.
  always_comb begin
    sum = {acc[AW-1], acc} + {{(L + 1){avg_i[7]}}, avg_i};
`ifdef MAVG_DECIM_ROUND_EN
    sum_adj = sum + (AW + 1)'((1 << L) >> 1);
`else
    sum_adj = sum;
`endif
    res_d = 8'(sum_adj >>> L);
  end

  // Accumulate accepted samples; on the block's last sample register the mean for the queue.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ph     <= '0;
      acc    <= '0;
      res_q  <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (avg_valid_i) begin
        if (last) begin
          ph     <= '0;
          acc    <= '0;
          res_q  <= res_d;
          push_q <= 1'b1;
        end else begin
          ph  <= ph + PHW'(1);
          acc <= sum[AW-1:0];
        end
      end
    end
  end

  // ---------------- output queue ----------------
  logic signed [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_left;
  logic              pop, full, push_ok, drop;
  logic signed [7:0] head_n;

  assign pop     = dec_valid_o & dec_ready_i;
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign push_ok = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;

  // Next-state queue view so dec_o/dec_valid_o can be registered with no bubble.
  always_comb begin
    cnt_left = cnt - CW'(pop);
    cnt_n    = cnt_left + CW'(push_ok);
    rd_n     = rd_ptr + PW'(pop);
    head_n   = '0;
    if (cnt_n == '0)         head_n = '0;
    else if (cnt_left == '0) head_n = res_q;   // queue drains and refills on the same edge
    else                     head_n = mem[rd_n];
  end

  // Queue storage; no reset needed because entries are only read once written.
  always_ff @(posedge system1000) begin
    if (push_ok) mem[wr_ptr] <= res_q;
  end

  // Queue pointers, registered head, and saturating drop counter.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      dec_o       <= '0;
      dec_valid_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      cnt         <= cnt_n;
      rd_ptr      <= rd_n;
      dec_o       <= head_n;
      dec_valid_o <= (cnt_n != '0);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

endmodule
